// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one ready/valid BRAM port between NPORTS requesters
module bram_arbiter #(
  parameter int NPORTS     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NPORTS-1:0]                i_req_valid,
  output logic [NPORTS-1:0]                o_req_ready,
  input  logic [NPORTS-1:0]                i_req_write,
  input  logic [NPORTS*ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]     i_req_data,
  input  logic [NPORTS*DATA_WIDTH/8-1:0]   i_req_be,
  output logic [NPORTS-1:0]                o_rsp_valid,
  input  logic [NPORTS-1:0]                i_rsp_ready,
  output logic [DATA_WIDTH-1:0]            o_rsp_data,
  output logic                             o_rsp_err,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_data,
  output logic [DATA_WIDTH/8-1:0]          o_mem_be,
  output logic                             o_mem_wr_valid,
  input  logic                             i_mem_wr_ready,
  output logic                             o_mem_rd_ready,
  input  logic                             i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]            i_mem_data,
  output logic                             o_busy
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = (NPORTS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_run;
  logic [PW-1:0]         r_ptr, r_grant, w_gnt, w_idx;
  logic                  w_found, w_accept, w_hs, w_tmo;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_rsp_data;
  logic [BW-1:0]         r_be;
  logic                  r_rsp_err;
  logic [7:0]            r_wd;

  // round-robin search starting one past the last served port
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NPORTS);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_accept = r_run && (r_state == IDLE) && w_found;
  assign w_hs     = ((r_state == WRITE) && i_mem_wr_ready) || ((r_state == READ) && i_mem_rd_valid);
  assign w_tmo    = (r_wd + 8'd1) == 8'(TIMEOUT);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next-state logic; the watchdog fires on the last allowed waiting cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = i_req_write[w_gnt] ? WRITE : READ;
      WRITE:   if (w_hs || w_tmo) w_next = RESP;
      READ:    if (w_hs || w_tmo) w_next = RESP;
      RESP:    if (i_rsp_ready[r_grant]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // request capture, watchdog, response capture and pointer update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run      <= 1'b0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_wd       <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_grant <= w_gnt;
        r_addr  <= i_req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
        r_data  <= i_req_data[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_be    <= i_req_be[w_gnt*BW +: BW];
        r_wd    <= '0;
      end
      if (r_state == WRITE || r_state == READ) begin
        r_wd <= r_wd + 8'd1;
        if (w_next == RESP) begin
          r_rsp_data <= ((r_state == READ) && i_mem_rd_valid) ? i_mem_data : '0;
          r_rsp_err  <= !w_hs;
        end
      end
      if (r_state == RESP && i_rsp_ready[r_grant]) r_ptr <= r_grant;
    end
  end

  // outputs decoded from state; the first idle cycle after reset grants nothing
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (w_accept) o_req_ready[w_gnt] = 1'b1;
    if (r_state == RESP) o_rsp_valid[r_grant] = 1'b1;
    o_rsp_data     = (r_state == RESP) ? r_rsp_data : '0;
    o_rsp_err      = (r_state == RESP) && r_rsp_err;
    o_mem_addr     = (r_state == WRITE || r_state == READ) ? r_addr : '0;
    o_mem_data     = (r_state == WRITE) ? r_data : '0;
    o_mem_be       = (r_state == WRITE) ? r_be : '0;
    o_mem_wr_valid = (r_state == WRITE);
    o_mem_rd_ready = (r_state == READ);
    o_busy         = (r_state != IDLE);
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed and randomized checking of bram_arbiter against a transaction-level model
module tb_bram_arbiter;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;
  localparam int TO = 15;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [NP-1:0]    i_req_valid, o_req_ready, i_req_write, o_rsp_valid, i_rsp_ready;
  logic [NP*AW-1:0] i_req_addr;
  logic [NP*DW-1:0] i_req_data;
  logic [NP*BW-1:0] i_req_be;
  logic [DW-1:0]    o_rsp_data, o_mem_data, i_mem_data;
  logic             o_rsp_err, o_mem_wr_valid, i_mem_wr_ready, o_mem_rd_ready, i_mem_rd_valid, o_busy;
  logic [AW-1:0]    o_mem_addr;
  logic [BW-1:0]    o_mem_be;

  int checks = 0;
  int errors = 0;

  logic [1:0]    mem_mode;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  logic          mem_init = 1'b0;
  logic          wr_rand = 1'b0;
  logic [NP-1:0] hs_req;

  bram_arbiter #(.NPORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_be(o_mem_be),
    .o_mem_wr_valid(o_mem_wr_valid), .i_mem_wr_ready(i_mem_wr_ready),
    .o_mem_rd_ready(o_mem_rd_ready), .i_mem_rd_valid(i_mem_rd_valid), .i_mem_data(i_mem_data),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory model: mode 0 ideal, mode 1 random stalls, mode 2 never responds
  assign i_mem_wr_ready = o_mem_wr_valid && (mem_mode == 2'd0 || (mem_mode == 2'd1 && wr_rand));

  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (o_mem_wr_valid && i_mem_wr_ready) begin
      for (int b = 0; b < BW; b++) if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_data[8*b +: 8];
    end
    i_mem_rd_valid <= i_rst_n && o_mem_rd_ready && !i_mem_rd_valid &&
                      (mem_mode == 2'd0 || (mem_mode == 2'd1 && $urandom_range(2) != 0));
    i_mem_data <= mem[o_mem_addr];
    wr_rand <= $urandom_range(3) != 0;
  end

  // transaction-level reference: one outstanding request, round-robin grant, watchdog bound
  initial begin
    int phase, ptr, cp, n, q;
    logic run_m, cw, ee;
    logic [NP-1:0] exp_rdy;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd, ed;
    logic [BW-1:0] cbe;
    phase = 0; ptr = 0; cp = 0; n = 0; run_m = 1'b0; cw = 1'b0; ee = 1'b0;
    ca = '0; cd = '0; ed = '0; cbe = '0; hs_req = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk("reset_outputs", {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_mem_addr, o_mem_data,
                              o_mem_be, o_mem_wr_valid, o_mem_rd_ready, o_busy}, '0);
        phase = 0; ptr = 0; run_m = 1'b0; hs_req = '0;
      end else begin
        hs_req = i_req_valid & o_req_ready;
        if (phase == 0) begin
          exp_rdy = '0;
          if (run_m)
            for (int k = 1; k <= NP; k++) begin
              q = (ptr + k) % NP;
              if (exp_rdy == '0 && i_req_valid[q]) exp_rdy[q] = 1'b1;
            end
          run_m = 1'b1;
          chk("req_ready", o_req_ready, exp_rdy);
          chk("idle_outputs", {o_rsp_valid, o_rsp_err, o_rsp_data, o_mem_addr, o_mem_data, o_mem_be,
                               o_mem_wr_valid, o_mem_rd_ready, o_busy}, '0);
          for (int k = 0; k < NP; k++)
            if (exp_rdy[k]) begin
              cp = k; cw = i_req_write[k]; ca = i_req_addr[k*AW +: AW];
              cd = i_req_data[k*DW +: DW]; cbe = i_req_be[k*BW +: BW];
              phase = 1; n = 0;
            end
        end else if (phase == 1) begin
          n++;
          chk("busy_mem", o_busy, 1);
          chk("ready_while_busy", o_req_ready, 0);
          chk("rsp_quiet", {o_rsp_valid, o_rsp_err, o_rsp_data}, 0);
          chk("mem_ctl", {o_mem_wr_valid, o_mem_rd_ready}, cw ? 2'b10 : 2'b01);
          chk("mem_addr", o_mem_addr, ca);
          chk("mem_wdata", {o_mem_data, o_mem_be}, cw ? {cd, cbe} : '0);
          if (cw && i_mem_wr_ready) begin
            for (int b = 0; b < BW; b++) if (cbe[b]) ref_mem[ca][8*b +: 8] = cd[8*b +: 8];
            ed = '0; ee = 1'b0; phase = 2;
          end else if (!cw && i_mem_rd_valid) begin
            ed = ref_mem[ca]; ee = 1'b0; phase = 2;
          end else if (n == TO) begin
            ed = '0; ee = 1'b1; phase = 2;
          end
        end else begin
          chk("rsp_valid", o_rsp_valid, 128'(1) << cp);
          chk("rsp_data", o_rsp_data, ed);
          chk("rsp_err", o_rsp_err, ee);
          chk("resp_quiet", {o_req_ready, o_mem_addr, o_mem_data, o_mem_be, o_mem_wr_valid, o_mem_rd_ready}, 0);
          chk("busy_resp", o_busy, 1);
          if (i_rsp_ready[cp]) begin
            ptr = cp; phase = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    i_req_valid[p] = 1'b1;
    i_req_write[p] = w;
    i_req_addr[p*AW +: AW] = a;
    i_req_data[p*DW +: DW] = d;
    i_req_be[p*BW +: BW] = be;
  endtask

  task automatic wait_ready(input int p);
    int t;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!o_req_ready[p] && t < 60);
    chk("accept", o_req_ready[p], 1);
  endtask

  task automatic wait_rsp(input int p, output int t);
    t = 0;
    do begin @(negedge i_clk); t++; end while (!o_rsp_valid[p] && t < 60);
  endtask

  task automatic xact(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input int lat, input logic [DW-1:0] xd, input logic xe);
    int t;
    @(posedge i_clk); #1;
    set_req(p, w, a, d, be);
    wait_ready(p);
    @(posedge i_clk); #1;
    i_req_valid[p] = 1'b0;
    wait_rsp(p, t);
    chk("latency", t, lat);
    chk("xact_data", o_rsp_data, xd);
    chk("xact_err", o_rsp_err, xe);
  endtask

  initial begin
    int t, g;
    logic [DW-1:0] d0;
    i_rst_n = 1'b0; mem_mode = 2'd0;
    i_req_valid = '0; i_req_write = '0; i_req_addr = '0; i_req_data = '0; i_req_be = '0; i_rsp_ready = '1;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // both ports hold reads: grants alternate starting at port 1
    @(posedge i_clk); #1;
    set_req(0, 1'b0, 10'h040, '0, '0);
    set_req(1, 1'b0, 10'h010, '0, '0);
    for (int i = 0; i < 6; i++) begin
      t = 0;
      do begin @(negedge i_clk); t++; end while (o_req_ready == '0 && t < 60);
      g = o_req_ready[1] ? 1 : 0;
      chk("alt_grant", g, (i % 2 == 0) ? 1 : 0);
      t = 0;
      do begin @(negedge i_clk); t++; end while (o_rsp_valid == '0 && t < 60);
      chk("alt_rsp_port", o_rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(posedge i_clk); #1;
    i_req_valid = '0;

    // write then read back, ideal memory latencies
    xact(0, 1'b1, 10'h040, 32'hDEADBEEF, 4'b1111, 2, 32'h0, 1'b0);
    xact(0, 1'b0, 10'h040, 32'h0, 4'b0000, 3, 32'hDEADBEEF, 1'b0);

    // byte-enable merge
    xact(1, 1'b1, 10'h010, 32'h11223344, 4'b1111, 2, 32'h0, 1'b0);
    xact(1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 2, 32'h0, 1'b0);
    xact(1, 1'b0, 10'h010, 32'h0, 4'b0000, 3, 32'h11BB33DD, 1'b0);

    // hung memory: error 15 cycles after READ entry, then normal service
    @(posedge i_clk); #1 mem_mode = 2'd2;
    xact(0, 1'b0, 10'h020, 32'h0, 4'b0000, TO + 1, 32'h0, 1'b1);
    @(posedge i_clk); #1 mem_mode = 2'd0;
    xact(0, 1'b0, 10'h040, 32'h0, 4'b0000, 3, 32'hDEADBEEF, 1'b0);

    // response back-pressure blocks the other pending request
    @(posedge i_clk); #1;
    i_rsp_ready = '0;
    set_req(0, 1'b0, 10'h040, '0, '0);
    set_req(1, 1'b0, 10'h010, '0, '0);
    t = 0;
    do begin @(negedge i_clk); t++; end while (o_req_ready == '0 && t < 60);
    chk("hold_first_grant", o_req_ready, 2'b10);
    @(posedge i_clk); #1 i_req_valid[1] = 1'b0;
    wait_rsp(1, t);
    d0 = o_rsp_data;
    chk("hold_rsp_data", d0, 32'h11BB33DD);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("hold_valid", o_rsp_valid, 2'b10);
      chk("hold_data", o_rsp_data, d0);
      chk("hold_block", o_req_ready, 2'b00);
    end
    @(posedge i_clk); #1 i_rsp_ready = '1;
    wait_ready(0);
    @(posedge i_clk); #1 i_req_valid[0] = 1'b0;
    wait_rsp(0, t);
    chk("release_data", o_rsp_data, 32'hDEADBEEF);

    // reset in the middle of a READ
    @(posedge i_clk); #1 mem_mode = 2'd2;
    set_req(0, 1'b0, 10'h033, '0, '0);
    wait_ready(0);
    @(posedge i_clk); #1 i_req_valid[0] = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1 chk("rst_async_zero", {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_mem_addr, o_mem_data,
                              o_mem_be, o_mem_wr_valid, o_mem_rd_ready, o_busy}, '0);
    @(posedge i_clk); #1;
    mem_mode = 2'd0;
    set_req(1, 1'b0, 10'h010, '0, '0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk); chk("rst_first_idle", o_req_ready, 2'b00);
    @(negedge i_clk); chk("rst_grant_p1", o_req_ready, 2'b10);
    @(posedge i_clk); #1 i_req_valid[1] = 1'b0;
    wait_rsp(1, t);
    chk("rst_rsp_data", o_rsp_data, 32'h11BB33DD);

    // randomized traffic with a stalling memory
    @(posedge i_clk); #1 mem_mode = 2'd1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs_req[p]) i_req_valid[p] = 1'b0;
        if (!i_req_valid[p] && $urandom_range(2) == 0)
          set_req(p, 1'($urandom_range(1)), 10'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
        i_rsp_ready[p] = $urandom_range(3) != 0;
      end
    end
    t = 0;
    do begin
      @(posedge i_clk); #1;
      for (int p = 0; p < NP; p++) if (hs_req[p]) i_req_valid[p] = 1'b0;
      i_rsp_ready = '1;
      t++;
    end while ((i_req_valid != '0 || o_busy) && t < 500);
    chk("drain", {i_req_valid, o_busy}, '0);

    repeat (3) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
